// File: rtl/vote_pkg.sv
// vote_pkg: shared ballot width, voter count and collector state type
package vote_pkg;
    localparam int BAL_W = 3;
    localparam int N_VOTERS = 5;
    localparam logic [BAL_W-1:0] ABSTAIN = 3'b000;
    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} coll_state_t;
endpackage

// File: rtl/session_timer.sv
// session_timer: counts COLLECT cycles and flags the last allowed one
module session_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (clr) r_cnt <= '0;
        else if (en) r_cnt <= r_cnt + 1'b1;
    end
    assign expire = r_cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/ballot_collector.sv
// ballot_collector: gathers five serial ballots into a stable parallel session
module ballot_collector #(
    parameter int TIMEOUT = 255,
    parameter int BAL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bal_valid,
    output logic             bal_ready,
    input  logic [2:0]       bal_id,
    input  logic [BAL_W-1:0] bal_data,
    output logic [BAL_W-1:0] bal1,
    output logic [BAL_W-1:0] bal2,
    output logic [BAL_W-1:0] bal3,
    output logic [BAL_W-1:0] bal4,
    output logic [BAL_W-1:0] bal5,
    output logic [4:0]       cast_mask,
    output logic             sess_valid,
    input  logic             sess_ack,
    output logic             timed_out,
    output logic             dup_err,
    output logic             bad_id
);
    vote_pkg::coll_state_t r_state, w_next;
    logic [BAL_W-1:0] r_bal [vote_pkg::N_VOTERS];
    logic [4:0] r_mask, w_hit, w_mask_next;
    logic r_to, r_dup, r_bad, w_open, w_collect, w_xfer, w_id_ok, w_full, w_expire;

    assign w_open      = r_state == vote_pkg::IDLE && start;
    assign w_collect   = r_state == vote_pkg::COLLECT;
    assign w_xfer      = w_collect && bal_valid;
    assign w_id_ok     = bal_id < 3'd5;
    assign w_hit       = w_id_ok ? 5'b00001 << bal_id : 5'b00000;
    assign w_mask_next = r_mask | (w_xfer ? w_hit : 5'b00000);
    assign w_full      = &w_mask_next;

    session_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_open),
        .en     (w_collect),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= vote_pkg::IDLE;
        else r_state <= w_next;
    end

    // completion is checked before expiry so a last-cycle final ballot wins
    always_comb begin
        w_next = r_state == vote_pkg::IDLE    ? (start ? vote_pkg::COLLECT : vote_pkg::IDLE)
               : r_state == vote_pkg::COLLECT ? (w_full || w_expire ? vote_pkg::PRESENT : vote_pkg::COLLECT)
               : (sess_ack ? vote_pkg::IDLE : vote_pkg::PRESENT);
    end

    always_comb begin
        bal_ready  = r_state == vote_pkg::COLLECT;
        sess_valid = r_state == vote_pkg::PRESENT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
            r_to   <= 1'b0;
            r_dup  <= 1'b0;
            r_bad  <= 1'b0;
            for (int k = 0; k < vote_pkg::N_VOTERS; k++) r_bal[k] <= '0;
        end else begin
            r_dup <= w_xfer && w_id_ok && (r_mask & w_hit) != 5'b00000;
            r_bad <= w_xfer && !w_id_ok;
            r_to  <= w_open ? 1'b0 : r_to | (w_collect && w_expire && !w_full);
            if (w_open) begin
                r_mask <= '0;
                for (int k = 0; k < vote_pkg::N_VOTERS; k++) r_bal[k] <= '0;
            end else if (w_xfer) begin
                r_mask <= w_mask_next;
                for (int k = 0; k < vote_pkg::N_VOTERS; k++)
                    if (w_hit[k] && !r_mask[k]) r_bal[k] <= bal_data;
            end
        end
    end

    assign bal1      = r_bal[0];
    assign bal2      = r_bal[1];
    assign bal3      = r_bal[2];
    assign bal4      = r_bal[3];
    assign bal5      = r_bal[4];
    assign cast_mask = r_mask;
    assign timed_out = r_to;
    assign dup_err   = r_dup;
    assign bad_id    = r_bad;
endmodule

// File: tb/tb_ballot_collector.sv
// tb_ballot_collector: directed and random sessions against a session-level model
module tb_ballot_collector;
    localparam int TO = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, bal_valid = 1'b0, sess_ack = 1'b0;
    logic [2:0] bal_id = '0, bal_data = '0;
    logic bal_ready, sess_valid, timed_out, dup_err, bad_id;
    logic [2:0] bal1, bal2, bal3, bal4, bal5;
    logic [4:0] cast_mask;
    int checks = 0, errors = 0;
    int m_phase, m_age;
    logic [2:0] m_val [5];
    logic [4:0] m_cast;
    logic m_to, m_dup, m_bad;

    ballot_collector #(.TIMEOUT(TO), .BAL_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bal_valid(bal_valid), .bal_ready(bal_ready),
        .bal_id(bal_id), .bal_data(bal_data), .bal1(bal1), .bal2(bal2), .bal3(bal3),
        .bal4(bal4), .bal5(bal5), .cast_mask(cast_mask), .sess_valid(sess_valid),
        .sess_ack(sess_ack), .timed_out(timed_out), .dup_err(dup_err), .bad_id(bad_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_age = 0;
        m_cast = '0;
        m_to = 1'b0;
        m_dup = 1'b0;
        m_bad = 1'b0;
        for (int i = 0; i < 5; i++) m_val[i] = '0;
    endtask

    // phase 0 = waiting for start, 1 = taking ballots, 2 = session on display
    task automatic model_edge(input logic s, input logic v, input logic [2:0] id,
                              input logic [2:0] d, input logic a);
        m_dup = 1'b0;
        m_bad = 1'b0;
        if (m_phase == 0) begin
            if (s) begin
                m_phase = 1;
                m_age = 0;
                m_cast = '0;
                m_to = 1'b0;
                for (int i = 0; i < 5; i++) m_val[i] = '0;
            end
        end else if (m_phase == 1) begin
            m_age++;
            if (v) begin
                if (id > 4) m_bad = 1'b1;
                else if (m_cast[id]) m_dup = 1'b1;
                else begin
                    m_val[id] = d;
                    m_cast[id] = 1'b1;
                end
            end
            if (m_cast == 5'b11111) m_phase = 2;
            else if (m_age == TO) begin
                m_phase = 2;
                m_to = 1'b1;
            end
        end else if (a) m_phase = 0;
    endtask

    task automatic check_all();
        chk("bal_ready", bal_ready, m_phase == 1);
        chk("sess_valid", sess_valid, m_phase == 2);
        chk("bal1", bal1, m_val[0]);
        chk("bal2", bal2, m_val[1]);
        chk("bal3", bal3, m_val[2]);
        chk("bal4", bal4, m_val[3]);
        chk("bal5", bal5, m_val[4]);
        chk("cast_mask", cast_mask, m_cast);
        chk("timed_out", timed_out, m_to);
        chk("dup_err", dup_err, m_dup);
        chk("bad_id", bad_id, m_bad);
    endtask

    task automatic step(input logic s, input logic v, input logic [2:0] id,
                        input logic [2:0] d, input logic a);
        start = s;
        bal_valid = v;
        bal_id = id;
        bal_data = d;
        sess_ack = a;
        @(posedge clk);
        model_edge(s, v, id, d, a);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        start = 1'b0;
        bal_valid = 1'b0;
        sess_ack = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        do_reset();
        // in-order session
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'(i), 3'(i + 1), 1'b0);
        chk("t1_valid", sess_valid, 1);
        chk("t1_bal1", bal1, 1);
        chk("t1_bal5", bal5, 5);
        chk("t1_mask", cast_mask, 5'b11111);
        chk("t1_to", timed_out, 0);
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
        chk("t1_ready", bal_ready, 0);
        chk("t1_bal3_held", bal3, 3);
        // duplicate and bad id, then timeout
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'd2, 3'd7, 1'b0);
        step(1'b0, 1'b1, 3'd2, 3'd1, 1'b0);
        chk("t2_dup", dup_err, 1);
        chk("t2_bal3", bal3, 7);
        chk("t2_mask", cast_mask, 5'b00100);
        idle(1);
        chk("t2_dup_off", dup_err, 0);
        step(1'b0, 1'b1, 3'd6, 3'd5, 1'b0);
        chk("t3_bad", bad_id, 1);
        chk("t3_mask", cast_mask, 5'b00100);
        idle(1);
        chk("t3_bad_off", bad_id, 0);
        idle(3);
        chk("t3_valid", sess_valid, 1);
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
        // timeout with two voters
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'd0, 3'd6, 1'b0);
        step(1'b0, 1'b1, 3'd3, 3'd6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("t4_early", sess_valid, 0);
        end
        idle(1);
        chk("t4_valid", sess_valid, 1);
        chk("t4_to", timed_out, 1);
        chk("t4_mask", cast_mask, 5'b01001);
        chk("t4_bal2", bal2, 0);
        chk("t4_bal4", bal4, 6);
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
        // completion in the last collect cycle
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'(i), 3'd2, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 3'd4, 3'd3, 1'b0);
        chk("t5_valid", sess_valid, 1);
        chk("t5_to", timed_out, 0);
        chk("t5_mask", cast_mask, 5'b11111);
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
        // reset mid-session, then start ignored while presenting
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'(i), 3'd5, 1'b0);
        do_reset();
        chk("t6_mask", cast_mask, 0);
        chk("t6_bal1", bal1, 0);
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'(4 - i), 3'(i), 1'b0);
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        chk("t6_hold", sess_valid, 1);
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
        chk("t6_ack", sess_valid, 0);
        // random traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(149) == 0) do_reset();
            else step($urandom_range(3) == 0, 1'($urandom), 3'($urandom), 3'($urandom),
                      $urandom_range(2) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ballot_collector.md
# ballot_collector

Upstream feeder for the 5-input, 3-bit majority voter. It opens a voting session and accepts one 3-bit ballot from each of five voter stations over a serial valid/ready channel. Duplicate and out-of-range IDs are rejected, and the session is closed when all ballots arrive or a timeout expires. The five ballots are then presented in parallel, held stable, on the voter's `in1`..`in5` inputs until downstream acknowledges.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles spent in COLLECT; legal range 1..65535.
- `BAL_W`, default 3: ballot width; must match the voter's input width.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: open a session; honoured only in IDLE.
- `bal_valid` input 1: ballot offered.
- `bal_ready` output 1: collector can accept; equals (state == COLLECT).
- `bal_id` input 3: voter station ID; legal values 0..4.
- `bal_data` input BAL_W: ballot value.
- `bal1`..`bal5` output BAL_W each: registered ballots for stations 0..4; connect to the voter's `in1`..`in5`.
- `cast_mask` output 5: bit k set when station k has voted this session.
- `sess_valid` output 1: session closed; ballots are stable.
- `sess_ack` input 1: downstream has consumed the session.
- `timed_out` output 1: session closed by timeout; valid while `sess_valid` is high.
- `dup_err` output 1: one-cycle pulse when a repeat ballot is rejected.
- `bad_id` output 1: one-cycle pulse when an ID greater than 4 is rejected.

## Operation
States: IDLE, COLLECT, PRESENT. Reset forces IDLE.
- **IDLE**
  - `start` = 1 → COLLECT.
  - On that same edge: clear `bal1`..`bal5` to 0, clear `cast_mask`, clear `timed_out`, clear the timer.
- **COLLECT**
  - A transfer occurs when `bal_valid` and `bal_ready` are both 1.
  - ID 0..4 with its mask bit clear: store `bal_data` in `bal(id+1)` and set mask bit `id`.
  - ID 0..4 with its mask bit already set: keep the stored value, pulse `dup_err` next cycle.
  - ID 5..7: nothing is stored, pulse `bad_id` next cycle.
  - Rejected transfers still complete the handshake; the offer is consumed.
  - `cast_mask` becomes 5'b11111 → PRESENT, `timed_out` = 0.
  - Timer equals TIMEOUT-1 and the mask is not full after this cycle's transfer → PRESENT, `timed_out` = 1.
- **PRESENT**
  - `sess_valid` = 1; the ballots, `cast_mask` and `timed_out` are all frozen.
  - `sess_ack` = 1 → IDLE.
- Missing stations leave their ballot at 3'b000, which counts as an abstention for the voter.
- Ballot outputs keep their values through IDLE until the next `start`.
- `start` is ignored in COLLECT and PRESENT.
- `sess_ack` is ignored outside PRESENT.

## Timing
- Reset values: state IDLE; all ballots 0; `cast_mask` 0; `sess_valid` 0; `timed_out` 0; `dup_err` 0; `bad_id` 0; timer 0.
- `bal_ready` goes high the cycle after `start` is sampled.
- A transfer on edge n updates the ballot and mask at edge n.
- If that transfer fills the mask, `sess_valid` is high starting cycle n+1 and `bal_ready` is low at n+1.
- Timer behaviour:
  - Starts at 0 on entry to COLLECT and increments once per COLLECT cycle.
  - COLLECT therefore lasts at most TIMEOUT cycles.
  - A transfer accepted in the final cycle is recorded.
  - If that final transfer completes the mask, `timed_out` = 0 (completion wins over timeout).
- `sess_ack` sampled on edge m: `sess_valid` = 0 at m+1.
- Back-to-back sessions are allowed: `start` at m+1 re-enters COLLECT at m+2.
- `dup_err` and `bad_id` are registered and last exactly one cycle.
- Reset asserted mid-session: immediate return to IDLE with all outputs at reset values; the partial session is discarded.
- Outputs do not depend combinationally on any input except through state; `bal_ready` is a function of state only.

## Structure
- Shared package `vote_pkg`:
  - `BAL_W` = 3.
  - `N_VOTERS` = 5.
  - `ABSTAIN` = 3'b000.
  - State enum `coll_state_t` {IDLE, COLLECT, PRESENT}.
- The voter block imports the same `BAL_W` and `N_VOTERS`.
- One sub-module, `session_timer`:
  - Inputs: `clk`, `rst`, `clr`, `en`.
  - Output: `expire`, high when count == TIMEOUT-1.
  - Counter width is $clog2(TIMEOUT+1).
- The remaining logic (FSM, ballot register file, mask, error pulses) stays in `ballot_collector`.

## Test plan
1. **In-order session:** reset, then `start`; IDs 0..4 with data 1,2,3,4,5 on consecutive cycles.
   - Required: `sess_valid` = 1 the cycle after the 5th transfer; `bal1`..`bal5` = 1..5; `cast_mask` = 5'b11111; `timed_out` = 0.
   - Then `sess_ack` → IDLE, `bal_ready` = 0.
2. **Duplicate ballot:** ID 2 data 7, then ID 2 data 1.
   - Required: `dup_err` pulses for one cycle; `bal3` stays 7; `cast_mask` = 5'b00100.
3. **Bad ID:** ID 6 data 5.
   - Required: one `bad_id` pulse; no ballot or mask change.
4. **Timeout:** TIMEOUT = 8; only IDs 0 and 3 vote, data 6.
   - Required: `sess_valid` = 1 exactly 8 cycles after COLLECT entry; `timed_out` = 1; `cast_mask` = 5'b01001; `bal2`, `bal3`, `bal5` = 0.
5. **Completion on the last cycle:** TIMEOUT = 8; the 5th distinct ID is accepted in COLLECT cycle 8.
   - Required: `timed_out` = 0 and `cast_mask` = 5'b11111.
6. **Reset mid-session and start ignored:**
   - `rst` pulsed after 3 ballots: all outputs return to reset values, state IDLE.
   - `start` asserted during PRESENT: ignored; `sess_valid` stays high until `sess_ack`.
